// File: rtl/rename_wide.sv
// rename_wide: N-wide register rename unit. Maps architectural sources and
// destinations to physical registers through a speculative RAT, allocates
// destinations from a free bitmap, and restores the RAT and rebuilds the free
// bitmap from the committed RAT on a flush.
module rename_wide #(
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PHYS_REGS  = 64,
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned FREE_PORTS = 2,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS),
  localparam int unsigned CW = $clog2(PHYS_REGS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH*AW-1:0]      in_rs1_i,
  input  logic [WIDTH*AW-1:0]      in_rs2_i,
  input  logic [WIDTH*AW-1:0]      in_rd_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH*PW-1:0]      out_p1_o,
  output logic [WIDTH*PW-1:0]      out_p2_o,
  output logic [WIDTH*PW-1:0]      out_pd_o,
  output logic [WIDTH*PW-1:0]      out_old_pd_o,
  input  logic [FREE_PORTS-1:0]    free_valid_i,
  input  logic [FREE_PORTS*PW-1:0] free_preg_i,
  input  logic [WIDTH-1:0]         commit_valid_i,
  input  logic [WIDTH*AW-1:0]      commit_rd_i,
  input  logic [WIDTH*PW-1:0]      commit_pd_i,
  input  logic                     flush_i
);

  logic [ARCH_REGS-1:0][PW-1:0] rat_q, rat_d, arat_q, arat_d;
  logic [PHYS_REGS-1:0]         free_q, free_d;
  logic [CW-1:0]                free_cnt_q, free_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [WIDTH*PW-1:0]          out_p1_q, out_p1_d, out_p2_q, out_p2_d;
  logic [WIDTH*PW-1:0]          out_pd_q, out_pd_d, out_old_q, out_old_d;

  logic [PHYS_REGS-1:0]         avail;
  logic [CW-1:0]                alloc_cnt;
  logic [WIDTH*PW-1:0]          ren_p1, ren_p2, ren_pd, ren_old;
  logic                         fire;

  assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i) && (free_cnt_q >= CW'(WIDTH));
  assign fire       = in_valid_i && in_ready_o;

  // Per-lane rename: lowest free register per lane in lane order, with
  // bypass of lower-lane destinations for RAW and WAW inside the group.
  always_comb begin
    avail     = free_q;
    alloc_cnt = '0;
    ren_p1    = '0;
    ren_p2    = '0;
    ren_pd    = '0;
    ren_old   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (in_rd_i[k*AW +: AW] != '0) begin
        // Descending scan leaves the lowest available index.
        for (int p = PHYS_REGS - 1; p >= 1; p--) begin
          if (avail[p]) ren_pd[k*PW +: PW] = PW'(p);
        end
        if (ren_pd[k*PW +: PW] != '0) begin
          avail[ren_pd[k*PW +: PW]] = 1'b0;
          alloc_cnt = alloc_cnt + CW'(1);
        end
        ren_old[k*PW +: PW] = rat_q[in_rd_i[k*AW +: AW]];
      end
      if (in_rs1_i[k*AW +: AW] != '0) ren_p1[k*PW +: PW] = rat_q[in_rs1_i[k*AW +: AW]];
      if (in_rs2_i[k*AW +: AW] != '0) ren_p2[k*PW +: PW] = rat_q[in_rs2_i[k*AW +: AW]];
      // Ascending over lower lanes so the highest matching lane wins.
      for (int j = 0; j < WIDTH; j++) begin
        if (j < k && in_rd_i[j*AW +: AW] != '0) begin
          if (in_rd_i[j*AW +: AW] == in_rs1_i[k*AW +: AW]) ren_p1[k*PW +: PW] = ren_pd[j*PW +: PW];
          if (in_rd_i[j*AW +: AW] == in_rs2_i[k*AW +: AW]) ren_p2[k*PW +: PW] = ren_pd[j*PW +: PW];
          if (in_rd_i[j*AW +: AW] == in_rd_i[k*AW +: AW]) ren_old[k*PW +: PW] = ren_pd[j*PW +: PW];
        end
      end
    end
  end

  // Next state: commits, then either flush recovery or release/allocate.
  always_comb begin
    arat_d      = arat_q;
    rat_d       = rat_q;
    free_d      = free_q;
    free_cnt_d  = free_cnt_q;
    out_valid_d = out_valid_q;
    out_p1_d    = out_p1_q;
    out_p2_d    = out_p2_q;
    out_pd_d    = out_pd_q;
    out_old_d   = out_old_q;
    for (int c = 0; c < WIDTH; c++) begin
      if (commit_valid_i[c] && commit_rd_i[c*AW +: AW] != '0) begin
        arat_d[commit_rd_i[c*AW +: AW]] = commit_pd_i[c*PW +: PW];
      end
    end
    if (flush_i) begin
      rat_d = arat_d;
      for (int p = 0; p < PHYS_REGS; p++) free_d[p] = (p != 0);
      for (int a = 0; a < ARCH_REGS; a++) free_d[arat_d[a]] = 1'b0;
      free_cnt_d = '0;
      for (int p = 0; p < PHYS_REGS; p++) free_cnt_d = free_cnt_d + CW'(free_d[p]);
      out_valid_d = 1'b0;
    end else begin
      // Checking free_d rather than free_q makes duplicate releases count once.
      for (int f = 0; f < FREE_PORTS; f++) begin
        if (free_valid_i[f] && free_preg_i[f*PW +: PW] != '0) begin
          if (!free_d[free_preg_i[f*PW +: PW]]) free_cnt_d = free_cnt_d + CW'(1);
          free_d[free_preg_i[f*PW +: PW]] = 1'b1;
        end
      end
      if (fire) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (in_rd_i[k*AW +: AW] != '0) begin
            rat_d[in_rd_i[k*AW +: AW]] = ren_pd[k*PW +: PW];
            free_d[ren_pd[k*PW +: PW]] = 1'b0;
          end
        end
        free_cnt_d  = free_cnt_d - alloc_cnt;
        out_valid_d = 1'b1;
        out_p1_d    = ren_p1;
        out_p2_d    = ren_p2;
        out_pd_d    = ren_pd;
        out_old_d   = ren_old;
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset restores identity maps and frees the upper range.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        arat_q[i] <= PW'(i);
      end
      for (int p = 0; p < PHYS_REGS; p++) free_q[p] <= (p >= int'(ARCH_REGS));
      free_cnt_q  <= CW'(PHYS_REGS - ARCH_REGS);
      out_valid_q <= 1'b0;
      out_p1_q    <= '0;
      out_p2_q    <= '0;
      out_pd_q    <= '0;
      out_old_q   <= '0;
    end else begin
      rat_q       <= rat_d;
      arat_q      <= arat_d;
      free_q      <= free_d;
      free_cnt_q  <= free_cnt_d;
      out_valid_q <= out_valid_d;
      out_p1_q    <= out_p1_d;
      out_p2_q    <= out_p2_d;
      out_pd_q    <= out_pd_d;
      out_old_q   <= out_old_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_p1_o     = out_p1_q;
  assign out_p2_o     = out_p2_q;
  assign out_pd_o     = out_pd_q;
  assign out_old_pd_o = out_old_q;

endmodule

// File: tb/tb_rename_wide.sv
// Bench for rename_wide: directed steps plus random traffic, checked against
// a lane-sequential behavioural model of the rename rules.
module tb_rename_wide;

  logic        clk;
  logic        rst_ni;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_rs1, in_rs2, in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_p1, out_p2, out_pd, out_old_pd;
  logic [1:0]  free_valid;
  logic [11:0] free_preg;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [11:0] commit_pd;
  logic        flush;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          m_rat[32];
  int          m_arat[32];
  bit          m_free[64];
  logic        e_valid;
  logic        e_ready;
  logic [11:0] e_p1, e_p2, e_pd, e_old;

  rename_wide dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_rs1_i       (in_rs1),
    .in_rs2_i       (in_rs2),
    .in_rd_i        (in_rd),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_p1_o       (out_p1),
    .out_p2_o       (out_p2),
    .out_pd_o       (out_pd),
    .out_old_pd_o   (out_old_pd),
    .free_valid_i   (free_valid),
    .free_preg_i    (free_preg),
    .commit_valid_i (commit_valid),
    .commit_rd_i    (commit_rd),
    .commit_pd_i    (commit_pd),
    .flush_i        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int p = 0; p < 64; p++) n += int'(m_free[p]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rat[i]  = i;
      m_arat[i] = i;
    end
    for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
    e_valid = 1'b0;
    e_p1 = '0; e_p2 = '0; e_pd = '0; e_old = '0;
  endtask

  // One clock of the rename rules: lanes processed strictly in order, each
  // seeing the RAT as updated by the lanes before it.
  task automatic model_step();
    bit fire;
    fire = in_valid && e_ready;
    if (fire) begin
      for (int k = 0; k < 2; k++) begin
        int rs1, rs2, rd, pd, old;
        rs1 = int'(in_rs1[k*5 +: 5]);
        rs2 = int'(in_rs2[k*5 +: 5]);
        rd  = int'(in_rd[k*5 +: 5]);
        pd  = 0;
        old = 0;
        e_p1[k*6 +: 6] = (rs1 == 0) ? 6'd0 : 6'(m_rat[rs1]);
        e_p2[k*6 +: 6] = (rs2 == 0) ? 6'd0 : 6'(m_rat[rs2]);
        if (rd != 0) begin
          old = m_rat[rd];
          for (int p = 1; p < 64; p++) begin
            if (m_free[p]) begin
              pd = p;
              break;
            end
          end
          m_free[pd] = 1'b0;
          m_rat[rd]  = pd;
        end
        e_pd[k*6 +: 6]  = 6'(pd);
        e_old[k*6 +: 6] = 6'(old);
      end
    end
    if (!flush) begin
      for (int f = 0; f < 2; f++) begin
        if (free_valid[f] && free_preg[f*6 +: 6] != 6'd0) m_free[int'(free_preg[f*6 +: 6])] = 1'b1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (commit_valid[c] && commit_rd[c*5 +: 5] != 5'd0) begin
        m_arat[int'(commit_rd[c*5 +: 5])] = int'(commit_pd[c*6 +: 6]);
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_rat[i] = m_arat[i];
      for (int p = 0; p < 64; p++) begin
        m_free[p] = (p != 0);
        for (int i = 0; i < 32; i++) if (m_arat[i] == p) m_free[p] = 1'b0;
      end
      e_valid = 1'b0;
    end else if (fire) begin
      e_valid = 1'b1;
    end else if (out_ready) begin
      e_valid = 1'b0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    e_ready = !flush && (!e_valid || out_ready) && (mcount() >= 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    check("out_p1", {20'd0, out_p1}, {20'd0, e_p1});
    check("out_p2", {20'd0, out_p2}, {20'd0, e_p2});
    check("out_pd", {20'd0, out_pd}, {20'd0, e_pd});
    check("out_old_pd", {20'd0, out_old_pd}, {20'd0, e_old});
    check("free_count", 32'(dut.free_cnt_q), 32'(mcount()));
  endtask

  task automatic clr();
    in_valid     = 1'b0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_rd        = '0;
    out_ready    = 1'b1;
    free_valid   = '0;
    free_preg    = '0;
    commit_valid = '0;
    commit_rd    = '0;
    commit_pd    = '0;
    flush        = 1'b0;
  endtask

  task automatic set_lane(input int k, input int rs1, input int rs2, input int rd);
    in_rs1[k*5 +: 5] = 5'(rs1);
    in_rs2[k*5 +: 5] = 5'(rs2);
    in_rd[k*5 +: 5]  = 5'(rd);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_free_count", 32'(dut.free_cnt_q), 32'd32);
    check("rst_rat5", 32'(dut.rat_q[5]), 32'd5);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    clr();
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pd", {20'd0, out_pd}, 32'd0);
    check("rst_old", {20'd0, out_old_pd}, 32'd0);
    rst_ni = 1'b1;
    cycle();

    // Intra-group RAW and WAW.
    in_valid = 1'b1;
    set_lane(0, 1, 2, 3);
    set_lane(1, 3, 0, 3);
    cycle();
    check("t2_l0_p1", {26'd0, out_p1[5:0]}, 32'd1);
    check("t2_l0_p2", {26'd0, out_p2[5:0]}, 32'd2);
    check("t2_l0_pd", {26'd0, out_pd[5:0]}, 32'd32);
    check("t2_l0_old", {26'd0, out_old_pd[5:0]}, 32'd3);
    check("t2_l1_p1", {26'd0, out_p1[11:6]}, 32'd32);
    check("t2_l1_p2", {26'd0, out_p2[11:6]}, 32'd0);
    check("t2_l1_pd", {26'd0, out_pd[11:6]}, 32'd33);
    check("t2_l1_old", {26'd0, out_old_pd[11:6]}, 32'd32);

    // rd = 0 in both lanes allocates nothing.
    set_lane(0, 4, 5, 0);
    set_lane(1, 6, 7, 0);
    cycle();
    check("t3_pd", {20'd0, out_pd}, 32'd0);
    check("t3_old", {20'd0, out_old_pd}, 32'd0);
    check("t3_count", 32'(dut.free_cnt_q), 32'd30);
    set_lane(0, 0, 0, 7);
    set_lane(1, 0, 0, 0);
    cycle();
    check("t3_next_alloc", {26'd0, out_pd[5:0]}, 32'd34);
    clr();

    // Exhaust the free list, then release two registers.
    do_reset();
    in_valid = 1'b1;
    for (int g = 0; g < 15; g++) begin
      set_lane(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31));
      set_lane(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31));
      cycle();
    end
    check("t4_count2", 32'(dut.free_cnt_q), 32'd2);
    set_lane(0, 1, 1, 9);
    set_lane(1, 2, 2, 10);
    #1;
    check("t4_ready16", {31'd0, in_ready}, 32'd1);
    cycle();
    free_valid = 2'b11;
    free_preg  = {6'd40, 6'd35};
    #1;
    check("t4_ready_low", {31'd0, in_ready}, 32'd0);
    cycle();
    free_valid = 2'b00;
    set_lane(0, 0, 0, 11);
    set_lane(1, 0, 0, 12);
    #1;
    check("t4_ready_back", {31'd0, in_ready}, 32'd1);
    cycle();
    check("t4_alloc35", {26'd0, out_pd[5:0]}, 32'd35);
    check("t4_alloc40", {26'd0, out_pd[11:6]}, 32'd40);

    // Back-pressure: outputs and RAT hold.
    out_ready = 1'b0;
    set_lane(0, 3, 4, 13);
    set_lane(1, 5, 6, 14);
    free_valid = 2'b01;
    free_preg  = {6'd0, 6'd50};
    cycle();
    free_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_rat13", 32'(dut.rat_q[13]), 32'(m_rat[13]));
      check("t5_rat11", 32'(dut.rat_q[11]), 32'(m_rat[11]));
    end
    clr();
    cycle();

    // Commit then flush restores the committed map.
    do_reset();
    in_valid = 1'b1;
    set_lane(0, 0, 0, 3);
    set_lane(1, 0, 0, 0);
    cycle();
    commit_valid = 2'b01;
    commit_rd    = {5'd0, 5'd3};
    commit_pd    = {6'd0, 6'd32};
    cycle();
    clr();
    flush = 1'b1;
    cycle();
    check("t6_rat3", 32'(dut.rat_q[3]), 32'd32);
    check("t6_free3", {31'd0, dut.free_q[3]}, 32'd1);
    check("t6_free33", {31'd0, dut.free_q[33]}, 32'd1);
    check("t6_free32", {31'd0, dut.free_q[32]}, 32'd0);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b1;
    set_lane(0, 3, 0, 0);
    cycle();
    check("t6_rs1_map", {26'd0, out_p1[5:0]}, 32'd32);
    clr();

    // Random traffic with legal releases.
    for (int n = 0; n < 400; n++) begin
      clr();
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        set_lane(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      for (int f = 0; f < 2; f++) begin
        int p;
        p = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1 && !m_free[p]) begin
          free_valid[f]       = 1'b1;
          free_preg[f*6 +: 6] = 6'(p);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        commit_valid = 2'($urandom_range(0, 3));
        commit_rd    = 10'($urandom);
        commit_pd    = {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63))};
      end
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end

    // Reset asserted while a group is held on the outputs.
    clr();
    flush = 1'b1;
    cycle();
    clr();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_lane(0, 1, 2, 3);
    set_lane(1, 4, 5, 6);
    cycle();
    check("t8_pre_valid", {31'd0, out_valid}, 32'd1);
    clr();
    do_reset();
    in_valid = 1'b1;
    set_lane(0, 5, 6, 7);
    set_lane(1, 7, 0, 0);
    cycle();
    check("t8_identity", {26'd0, out_p1[5:0]}, 32'd5);
    check("t8_bypass", {26'd0, out_p1[11:6]}, 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
